// File: rtl/bus_define.sv
// Shared AHB definitions: HTRANS encodings, handover FSM states and a transfer-type helper.
package bus_define;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_OWN     = 2'd1,
        ST_LOCKED  = 2'd2
    } handover_state_e;

    localparam int MASTER_IDX_W = 4;

    // True when the transfer will produce a real data phase.
    function automatic logic is_transfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// Lowest-index priority encoder with valid and multi-hot flags; shared with the bus decoder.
module onehot_to_idx
    import bus_define::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              vec_i,
    output logic [MASTER_IDX_W-1:0]   idx_o,
    output logic                      valid_o,
    output logic                      multi_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = MASTER_IDX_W'(i);
            end
        end
    end

    assign valid_o = |vec_i;
    assign multi_o = (vec_i & (vec_i - N'(1))) != '0;

endmodule

// File: rtl/ahb_master_handover.sv
// Turns arbiter grant/lock into HREADY-aligned address/data selects, HMASTER and HMASTLOCK,
// with a data-phase stall watchdog.
module ahb_master_handover
    import bus_define::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int TIMEOUT        = 255
) (
    input  logic                    HCLK,
    input  logic                    rst,
    input  logic [NUM_MASTERS-1:0]  HGRANT_i,
    input  logic                    HBUSLOCK_i,
    input  logic                    HREADY_i,
    input  logic [1:0]              HTRANS_i,
    output logic [NUM_MASTERS-1:0]  addr_sel_o,
    output logic [NUM_MASTERS-1:0]  data_sel_o,
    output logic [3:0]              HMASTER_o,
    output logic                    HMASTLOCK_o,
    output logic                    data_active_o,
    output logic                    handover_o,
    output logic                    grant_err_o,
    output logic                    timeout_o
);

    localparam logic [MASTER_IDX_W-1:0] DEF_IDX = MASTER_IDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0]  DEF_SEL = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [15:0]             WD_MAX  = 16'hFFFF;
    localparam logic [15:0]             WD_TRIP = 16'(TIMEOUT);

    logic [MASTER_IDX_W-1:0] gnt_idx;
    logic                    gnt_valid;
    logic                    gnt_multi;

    onehot_to_idx #(.N(NUM_MASTERS)) u_gnt_enc (
        .vec_i   (HGRANT_i),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid),
        .multi_o (gnt_multi)
    );

    handover_state_e         state_q, state_d;
    logic [MASTER_IDX_W-1:0] owner_q, owner_d;
    logic [NUM_MASTERS-1:0]  addr_sel_q, addr_sel_d;
    logic [NUM_MASTERS-1:0]  data_sel_q, data_sel_d;
    logic                    mastlock_q, mastlock_d;
    logic                    data_active_q, data_active_d;
    logic                    handover_q, handover_d;
    logic                    grant_err_q, grant_err_d;
    logic [15:0]             wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    frozen;

    // A held lock keeps the owner; a lock release is seen first so the grant on that edge wins.
    assign frozen = (state_q == ST_LOCKED) && HBUSLOCK_i;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_sel_d    = addr_sel_q;
        data_sel_d    = data_sel_q;
        mastlock_d    = mastlock_q;
        data_active_d = data_active_q;
        handover_d    = 1'b0;
        grant_err_d   = 1'b0;
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = timeout_q;

        if (HREADY_i) begin
            if (!frozen) begin
                owner_d     = gnt_valid ? gnt_idx : DEF_IDX;
                grant_err_d = gnt_multi;
            end
            if (HBUSLOCK_i) begin
                state_d = ST_LOCKED;
            end else begin
                state_d = gnt_valid ? ST_OWN : ST_DEFAULT;
            end
            addr_sel_d    = NUM_MASTERS'(1) << owner_d;
            data_sel_d    = addr_sel_q;
            mastlock_d    = HBUSLOCK_i;
            data_active_d = is_transfer(HTRANS_i);
            handover_d    = (owner_d != owner_q);
            wd_cnt_d      = '0;
        end else if (data_active_q && (wd_cnt_q != WD_MAX)) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
            if (wd_cnt_d == WD_TRIP) begin
                timeout_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (rst) begin
            state_q       <= ST_DEFAULT;
            owner_q       <= DEF_IDX;
            addr_sel_q    <= DEF_SEL;
            data_sel_q    <= DEF_SEL;
            mastlock_q    <= 1'b0;
            data_active_q <= 1'b0;
            handover_q    <= 1'b0;
            grant_err_q   <= 1'b0;
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_sel_q    <= addr_sel_d;
            data_sel_q    <= data_sel_d;
            mastlock_q    <= mastlock_d;
            data_active_q <= data_active_d;
            handover_q    <= handover_d;
            grant_err_q   <= grant_err_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign addr_sel_o    = addr_sel_q;
    assign data_sel_o    = data_sel_q;
    assign HMASTER_o     = owner_q;
    assign HMASTLOCK_o   = mastlock_q;
    assign data_active_o = data_active_q;
    assign handover_o    = handover_q;
    assign grant_err_o   = grant_err_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ahb_master_handover.sv
// Directed plus randomized bench for ahb_master_handover against a cycle-level ownership model.
module tb_ahb_master_handover;

    localparam int NM = 4;
    localparam int DM = 0;
    localparam int TO = 4;

    logic          HCLK = 1'b0;
    logic          rst;
    logic [NM-1:0] HGRANT_i;
    logic          HBUSLOCK_i;
    logic          HREADY_i;
    logic [1:0]    HTRANS_i;
    logic [NM-1:0] addr_sel_o;
    logic [NM-1:0] data_sel_o;
    logic [3:0]    HMASTER_o;
    logic          HMASTLOCK_o;
    logic          data_active_o;
    logic          handover_o;
    logic          grant_err_o;
    logic          timeout_o;

    ahb_master_handover #(
        .NUM_MASTERS    (NM),
        .DEFAULT_MASTER (DM),
        .TIMEOUT        (TO)
    ) dut (
        .HCLK          (HCLK),
        .rst           (rst),
        .HGRANT_i      (HGRANT_i),
        .HBUSLOCK_i    (HBUSLOCK_i),
        .HREADY_i      (HREADY_i),
        .HTRANS_i      (HTRANS_i),
        .addr_sel_o    (addr_sel_o),
        .data_sel_o    (data_sel_o),
        .HMASTER_o     (HMASTER_o),
        .HMASTLOCK_o   (HMASTLOCK_o),
        .data_active_o (data_active_o),
        .handover_o    (handover_o),
        .grant_err_o   (grant_err_o),
        .timeout_o     (timeout_o)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the address phase, who owned the previous one, lock and stall count.
    int m_owner, m_data_owner, m_stall;
    bit m_lock, m_active, m_handover, m_gerr, m_timeout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        int new_owner;
        int ones;
        if (rst) begin
            m_owner = DM; m_data_owner = DM; m_stall = 0;
            m_lock = 0; m_active = 0; m_handover = 0; m_gerr = 0; m_timeout = 0;
        end else begin
            m_handover = 0;
            m_gerr     = 0;
            if (HREADY_i) begin
                new_owner = m_owner;
                if (!(m_lock && HBUSLOCK_i)) begin
                    ones      = $countones(HGRANT_i);
                    new_owner = DM;
                    for (int i = NM - 1; i >= 0; i--) if (HGRANT_i[i]) new_owner = i;
                    m_gerr = (ones > 1);
                end
                m_data_owner = m_owner;
                m_handover   = (new_owner != m_owner);
                m_owner      = new_owner;
                m_lock       = HBUSLOCK_i;
                m_active     = (HTRANS_i >= 2'd2);
                m_stall      = 0;
            end else if (m_active) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall == TO) m_timeout = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [NM-1:0] exp_addr;
        logic [NM-1:0] exp_data;
        exp_addr = NM'(1) << m_owner;
        exp_data = NM'(1) << m_data_owner;
        check_val({tag, ".addr_sel"},  32'(addr_sel_o),    32'(exp_addr));
        check_val({tag, ".data_sel"},  32'(data_sel_o),    32'(exp_data));
        check_val({tag, ".hmaster"},   32'(HMASTER_o),     32'(m_owner));
        check_val({tag, ".mastlock"},  32'(HMASTLOCK_o),   32'(m_lock));
        check_val({tag, ".active"},    32'(data_active_o), 32'(m_active));
        check_val({tag, ".handover"},  32'(handover_o),    32'(m_handover));
        check_val({tag, ".grant_err"}, 32'(grant_err_o),   32'(m_gerr));
        check_val({tag, ".timeout"},   32'(timeout_o),     32'(m_timeout));
    endtask

    task automatic step(input string tag, input logic r, input logic [NM-1:0] g,
                        input logic lk, input logic rdy, input logic [1:0] tr);
        rst = r; HGRANT_i = g; HBUSLOCK_i = lk; HREADY_i = rdy; HTRANS_i = tr;
        @(posedge HCLK);
        model_update();
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1; HGRANT_i = '0; HBUSLOCK_i = 1'b0; HREADY_i = 1'b1; HTRANS_i = 2'd0;
        #1;

        step("reset0", 1, 4'b0000, 0, 1, 2'd0);
        step("reset1", 1, 4'b0100, 1, 1, 2'd2);
        check_val("reset.addr_sel", 32'(addr_sel_o), 32'h1);
        check_val("reset.hmaster",  32'(HMASTER_o),  32'h0);

        step("grant2", 0, 4'b0100, 0, 1, 2'd2);
        check_val("grant2.addr_sel", 32'(addr_sel_o), 32'h4);
        check_val("grant2.hmaster",  32'(HMASTER_o),  32'h2);
        check_val("grant2.handover", 32'(handover_o), 32'h1);
        step("grant2b", 0, 4'b0100, 0, 1, 2'd2);
        check_val("grant2b.data_sel", 32'(data_sel_o), 32'h4);

        for (int i = 0; i < 3; i++) begin
            step("stall_grant", 0, 4'b0010, 0, 0, 2'd0);
            check_val("stall_grant.hmaster", 32'(HMASTER_o), 32'h2);
        end
        step("release1", 0, 4'b0010, 0, 1, 2'd0);
        check_val("release1.hmaster",  32'(HMASTER_o),  32'h1);
        check_val("release1.handover", 32'(handover_o), 32'h1);

        step("lock3", 0, 4'b1000, 1, 1, 2'd2);
        step("lock3_hold", 0, 4'b0001, 1, 1, 2'd3);
        check_val("lock3_hold.hmaster",  32'(HMASTER_o),   32'h3);
        check_val("lock3_hold.mastlock", 32'(HMASTLOCK_o), 32'h1);
        step("unlock0", 0, 4'b0001, 0, 1, 2'd0);
        check_val("unlock0.hmaster", 32'(HMASTER_o), 32'h0);

        step("multihot", 0, 4'b1010, 0, 1, 2'd0);
        check_val("multihot.hmaster",   32'(HMASTER_o),   32'h1);
        check_val("multihot.grant_err", 32'(grant_err_o), 32'h1);
        step("nogrant", 0, 4'b0000, 0, 1, 2'd0);
        check_val("nogrant.hmaster", 32'(HMASTER_o), 32'(DM));

        step("wd_start", 0, 4'b0001, 0, 1, 2'd2);
        for (int i = 1; i <= 4; i++) begin
            step("wd_stall", 0, 4'b0001, 0, 0, 2'd2);
            check_val("wd_stall.timeout", 32'(timeout_o), (i == 4) ? 32'h1 : 32'h0);
        end
        step("wd_ready", 0, 4'b0001, 0, 1, 2'd0);
        check_val("wd_ready.timeout", 32'(timeout_o), 32'h1);
        step("wd_rst", 1, 4'b0001, 0, 1, 2'd0);
        check_val("wd_rst.timeout", 32'(timeout_o), 32'h0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 59) == 0),
                 NM'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_master_handover.md
# ahb_master_handover

Sequencing controller that sits between the AHB arbiter and the master-side multiplexers. It converts the arbiter's one-hot grant and bus-lock outputs into registered selects: an address-phase select, a one-cycle-delayed data-phase select, `HMASTER` and `HMASTLOCK`. Every handover is aligned to `HREADY`, ownership is frozen during locked sequences, and stalled data phases are detected by a watchdog.

## Interface
- `NUM_MASTERS`, default 4, number of masters (1..16).
- `DEFAULT_MASTER`, default 0, index that owns the bus when no grant is asserted.
- `TIMEOUT`, default 255, number of consecutive `HREADY`-low data-phase cycles that trips the watchdog (1..65535).
- `HCLK`  in  1  bus clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `HGRANT_i`  in  NUM_MASTERS  one-hot grant from the arbiter.
- `HBUSLOCK_i`  in  1  lock request from the arbiter for the granted master.
- `HREADY_i`  in  1  bus ready (slave-side, after the slave mux).
- `HTRANS_i`  in  2  HTRANS of the current address-phase master, already muxed with `addr_sel_o`.
- `addr_sel_o`  out  NUM_MASTERS  one-hot address-phase mux select.
- `data_sel_o`  out  NUM_MASTERS  one-hot write-data mux select.
- `HMASTER_o`  out  4  binary index of the address-phase owner.
- `HMASTLOCK_o`  out  1  locked-transfer indicator.
- `data_active_o`  out  1  the current data phase carries NONSEQ/SEQ.
- `handover_o`  out  1  one-cycle pulse when the address owner changes.
- `grant_err_o`  out  1  one-cycle pulse when a non-one-hot grant is sampled.
- `timeout_o`  out  1  sticky watchdog flag, cleared only by `rst`.

## Operation
- States: `DEFAULT` (no grant, DEFAULT_MASTER owns), `OWN` (a granted master owns), `LOCKED` (owner frozen).
- All updates occur only on edges where `HREADY_i`=1, except the watchdog. When `HREADY_i`=0, every select, `HMASTER_o`, `HMASTLOCK_o` and the state hold.
- Next owner on an `HREADY_i`=1 edge:
  - `LOCKED`: the current owner is kept regardless of `HGRANT_i`.
  - Otherwise: the index of `HGRANT_i`.
  - `HGRANT_i`=0: DEFAULT_MASTER, next state `DEFAULT`.
  - More than one bit set: the lowest set index, with `grant_err_o`=1 for that cycle.
- Next state:
  - `LOCKED` if `HBUSLOCK_i`=1.
  - From `LOCKED`, exit to `OWN` or `DEFAULT` when `HBUSLOCK_i`=0 is sampled.
- `HMASTLOCK_o` is loaded with `HBUSLOCK_i` on each `HREADY_i`=1 edge.
- `data_sel_o` is loaded with the old `addr_sel_o` on each `HREADY_i`=1 edge.
- `data_active_o` is loaded with (`HTRANS_i`[1]==1) on each `HREADY_i`=1 edge.
- `handover_o`=1 for one cycle when the newly loaded owner differs from the previous owner.
- Watchdog:
  - A 16-bit counter increments while `data_active_o`=1 and `HREADY_i`=0.
  - It clears on `HREADY_i`=1 and saturates.
  - When the count reaches `TIMEOUT`, `timeout_o` is set.
- `HMASTER_o` upper bits are zero when NUM_MASTERS < 16.

## Timing
- Reset values:
  - `addr_sel_o` and `data_sel_o` = one-hot(DEFAULT_MASTER); `HMASTER_o`=DEFAULT_MASTER.
  - `HMASTLOCK_o`, `data_active_o`, `handover_o`, `grant_err_o`, `timeout_o` = 0.
  - State = `DEFAULT`, counter = 0.
- Latency:
  - Grant sampled at edge N (with `HREADY_i`=1) drives `addr_sel_o` and `HMASTER_o` after edge N.
  - `data_sel_o` follows one `HREADY_i`=1 edge later.
- Simultaneous lock release and grant change: the release is sampled first, so the new grant is honoured on the same edge.
- `rst` mid-transfer: all outputs return to their reset values on the next edge, and the watchdog clears. No partial handover is completed.
- Grant change while `HREADY_i`=0: ignored until `HREADY_i`=1, at which point the grant value present on that edge is used.

## Structure
- Shared package `bus_define`: `HTRANS` encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and the state encoding for `DEFAULT`/`OWN`/`LOCKED`.
- One sub-module, `onehot_to_idx`: combinational priority encoder returning the lowest set index, a valid flag and a multi-hot flag. It is reused by the bus decoder.

## Test plan
- Reset with NUM_MASTERS=4 and DEFAULT_MASTER=0:
  - `addr_sel_o`=4'b0001, `HMASTER_o`=0, all flags 0.
- `HGRANT_i`=4'b0100 with `HREADY_i`=1:
  - Next cycle `addr_sel_o`=4'b0100, `HMASTER_o`=2, `handover_o` pulse.
  - One cycle later `data_sel_o`=4'b0100.
- Grant moves to 4'b0010 while `HREADY_i`=0 for 3 cycles:
  - Owner stays 2.
  - The handover to 1 occurs on the first `HREADY_i`=1 edge.
- `HBUSLOCK_i`=1 with owner 3, then `HGRANT_i`=4'b0001 during the lock:
  - Owner stays 3 and `HMASTLOCK_o`=1.
  - Dropping the lock and keeping grant 4'b0001 gives owner 0 on that edge.
- `HGRANT_i`=4'b1010:
  - Owner 1, `grant_err_o` pulse.
  - `HGRANT_i`=0 next gives owner DEFAULT_MASTER and state `DEFAULT`.
- TIMEOUT=4, NONSEQ data phase, `HREADY_i` held low:
  - `timeout_o`=1 after the 4th stalled cycle.
  - It remains 1 after `HREADY_i` returns, and clears only on `rst`.
